// File: rtl/linalg_pkg.sv
// Shared linear-algebra types: float32 word, bank state enum,
// a handy constant and the index-counter width helper.
package linalg_pkg;

  typedef logic [31:0] float32_t;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_state_t;

  localparam float32_t FLOAT_ONE = 32'h3F800000;

  // Width of an index that counts N-1 down to 0 (at least 1 bit).
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_assembler_if.sv
// Scalar-in / vector-out stb/ack bundle for vector_assembler.
// master = producer+consumer side, slave = the assembler.
interface vector_assembler_if
  import linalg_pkg::*;
#(
  parameter int N = 4
);

  float32_t         input_elem;
  logic             input_elem_stb;
  logic             input_elem_ack;
  float32_t [N-1:0] output_vec;
  logic             output_vec_stb;
  logic             output_vec_ack;

  modport master (
    output input_elem,
    output input_elem_stb,
    input  input_elem_ack,
    input  output_vec,
    input  output_vec_stb,
    output output_vec_ack
  );

  modport slave (
    input  input_elem,
    input  input_elem_stb,
    output input_elem_ack,
    output output_vec,
    output output_vec_stb,
    input  output_vec_ack
  );

endinterface

// File: rtl/vec_bank.sv
// One N x float32 vector buffer with indexed write and EMPTY/FILLING/FULL
// state. Ports: wr_en/wr_idx/wr_data write, clear empties, data/state out.
module vec_bank
  import linalg_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [idx_w(N)-1:0]    wr_idx,
  input  float32_t               wr_data,
  output float32_t [N-1:0]       data,
  output bank_state_t            state
);

  localparam int IW = idx_w(N);

  bank_state_t state_d;
  logic        wr_last;

  // Index 0 is the final element of a vector.
  assign wr_last = (wr_idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_d;
    end
  end

  // clear targets the presented (FULL) bank and writes target the
  // fill (not FULL) bank, so the two never hit the same bank.
  always_comb begin
    state_d = state;
    unique case (1'b1)
      clear:              state_d = EMPTY;
      wr_en && wr_last:   state_d = FULL;
      wr_en && !wr_last:  state_d = FILLING;
      default:            state_d = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_en && wr_idx == IW'(i)) begin
          data[i] <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/vector_assembler.sv
// Packs a float32 scalar stream into N-element vectors, ping-pong banked.
// Ports: clk, rst (async active-low), bus (slave side of the handshakes).
module vector_assembler
  import linalg_pkg::*;
#(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,
  vector_assembler_if.slave  bus
);

  localparam int            IW      = idx_w(N);
  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

  logic             wr_ptr;
  logic             rd_ptr;
  logic             rdy_q;
  logic [IW-1:0]    idx_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             idx_last;

  float32_t [N-1:0] bank_data [2];
  bank_state_t      bank_st   [2];

  // rdy_q keeps ack low through reset and lifts it one edge later.
  assign bus.input_elem_ack = rdy_q && (bank_st[wr_ptr] != FULL);
  assign bus.output_vec_stb = (bank_st[rd_ptr] == FULL);
  assign bus.output_vec     = bank_data[rd_ptr];

  assign in_xfer  = bus.input_elem_stb && bus.input_elem_ack;
  assign out_xfer = bus.output_vec_stb && bus.output_vec_ack;
  assign idx_last = (idx_q == '0);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    vec_bank #(.N(N)) u_bank (
      .clk     (clk),
      .rst_n   (rst),
      .clear   (out_xfer && rd_ptr == 1'(b)),
      .wr_en   (in_xfer && wr_ptr == 1'(b)),
      .wr_idx  (idx_q),
      .wr_data (bus.input_elem),
      .data    (bank_data[b]),
      .state   (bank_st[b])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q  <= 1'b0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      idx_q  <= IDX_TOP;
    end else begin
      rdy_q <= 1'b1;
      if (in_xfer) begin
        if (idx_last) begin
          idx_q  <= IDX_TOP;
          wr_ptr <= ~wr_ptr;
        end else begin
          idx_q  <= idx_q - 1'b1;
        end
      end
      if (out_xfer) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

endmodule
